// File: rtl/ecc_mem_ctrl.sv
// ECC-protected 12-bit codeword store behind a valid/ready request port with detect-only checking.
// Optional background scrubber enabled by defining ECC_SCRUB_EN.
module ecc_mem_ctrl #(
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned SCRUB_INTERVAL = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    input  logic [11:0]       req_inj_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_count,
    output logic              scrub_err,
    output logic [ADDR_W-1:0] scrub_err_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

`ifdef ECC_SCRUB_EN
    typedef enum logic [2:0] {
        StIdle, StWrite, StRead, StCheck, StResp, StScrubRd, StScrubChk
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StWrite, StRead, StCheck, StResp
    } state_e;
`endif

    function automatic logic [3:0] parity(input logic [7:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[2];
        p[1] = d[1] ^ d[3] ^ d[4];
        p[2] = d[2] ^ d[5] ^ d[6];
        p[3] = d[3] ^ d[6] ^ d[7];
        return p;
    endfunction

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          wdata_q;
    logic [11:0]         mask_q;
    logic [11:0]         cw_q;
    logic [11:0]         mem_q [DEPTH];
    logic [7:0]          err_count_q;
    logic                err_inc;
    logic                syn_err;

    assign syn_err = |(parity(cw_q[11:4]) ^ cw_q[3:0]);

`ifdef ECC_SCRUB_EN
    localparam int unsigned CNT_W = $clog2(SCRUB_INTERVAL);

    logic [CNT_W-1:0]  idle_cnt_q;
    logic [ADDR_W-1:0] scrub_addr_q;
    logic              scrub_err_q;
    logic [ADDR_W-1:0] scrub_err_addr_q;
`endif

    always_comb begin
        state_d = state_q;
        err_inc = 1'b0;
        case (state_q)
            StIdle: begin
                // A live request always beats a due scrub.
                if (req_valid) begin
                    state_d = req_we ? StWrite : StRead;
                end
`ifdef ECC_SCRUB_EN
                else if (idle_cnt_q == CNT_W'(SCRUB_INTERVAL - 1)) begin
                    state_d = StScrubRd;
                end
`endif
            end
            StWrite: state_d = StIdle;
            StRead:  state_d = StCheck;
            StCheck: begin
                err_inc = syn_err;
                state_d = rsp_ready ? StIdle : StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
`ifdef ECC_SCRUB_EN
            StScrubRd:  state_d = StScrubChk;
            StScrubChk: begin
                err_inc = syn_err;
                state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
            cw_q        <= '0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                addr_q <= req_addr;
                if (req_we) begin
                    wdata_q <= req_wdata;
                    mask_q  <= req_inj_mask;
                end
            end
            if (state_q == StRead) begin
                cw_q <= mem_q[addr_q];
            end
`ifdef ECC_SCRUB_EN
            if (state_q == StScrubRd) begin
                cw_q <= mem_q[scrub_addr_q];
            end
`endif
            if (err_inc && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Reset loads all-zero entries, which are valid codewords.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == StWrite) begin
            mem_q[addr_q] <= {wdata_q, parity(wdata_q)} ^ mask_q;
        end
    end

`ifdef ECC_SCRUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q       <= '0;
            scrub_addr_q     <= '0;
            scrub_err_q      <= 1'b0;
            scrub_err_addr_q <= '0;
        end else begin
            if (state_q == StIdle && state_d == StIdle) begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end else begin
                idle_cnt_q <= '0;
            end
            if (state_q == StScrubChk) begin
                scrub_addr_q <= scrub_addr_q + ADDR_W'(1);
                if (syn_err) begin
                    scrub_err_q      <= 1'b1;
                    scrub_err_addr_q <= scrub_addr_q;
                end
            end
        end
    end

    assign scrub_err      = scrub_err_q;
    assign scrub_err_addr = scrub_err_addr_q;
`else
    assign scrub_err      = 1'b0;
    assign scrub_err_addr = '0;
`endif

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StCheck) || (state_q == StResp);
    assign rsp_rdata = rsp_valid ? cw_q[11:4] : 8'h00;
    assign rsp_err   = rsp_valid && syn_err;
    assign err_count = err_count_q;

endmodule
